// File: rtl/wb_result_arbiter_pkg.sv
// Shared writeback types: result micro-op, branch provider, sequence numbers,
// plus the writeback arbiter sizing constants and a wrap-aware age helper.
package wb_result_arbiter_pkg;

    localparam int SQN_W  = 7;
    localparam int TAG_W  = 7;
    localparam int NM_W   = 5;
    localparam int DATA_W = 32;
    localparam int FLAG_W = 4;

    localparam int FIFO_DEPTH_WB   = 4;
    localparam int STARVE_LIMIT_WB = 3;

    typedef logic [SQN_W-1:0] SqN;

    typedef struct packed {
        logic [TAG_W-1:0]  tagDst;
        SqN                sqN;
        logic [NM_W-1:0]   nmDst;
        logic [DATA_W-1:0] result;
        logic [FLAG_W-1:0] flags;
    } RES_UOp;

    typedef struct packed {
        logic taken;
        SqN   sqN;
    } BranchProv;

    // True when a is strictly younger than b, i.e. $signed(a - b) > 0 across wrap.
    function automatic logic sqn_younger(input SqN a, input SqN b);
        SqN d;
        d = a - b;
        return !d[SQN_W-1] && (d != '0);
    endfunction

endpackage

// File: rtl/wb_flush_fifo.sv
// Shift-register result buffer: entry 0 is the oldest; survivors of a flush
// and of a pop are compacted toward entry 0 and a push lands at the insert index.
module wb_flush_fifo
    import wb_result_arbiter_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_WB
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  RES_UOp push_uop,
    input  logic   pop,
    input  logic   flush,
    input  SqN     flush_sqn,
    output RES_UOp head,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    RES_UOp          entries [DEPTH];
    RES_UOp          entries_nxt [DEPTH];
    logic [CW-1:0]   count;
    logic [CW-1:0]   wr_idx;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries_nxt[i] = '0;
        end
        wr_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count && !(pop && i == 0) &&
                !(flush && sqn_younger(entries[i].sqN, flush_sqn))) begin
                entries_nxt[wr_idx[AW-1:0]] = entries[i];
                wr_idx = wr_idx + 1'b1;
            end
        end
        // The caller only pushes when a slot is free, so the guard never drops data.
        if (push && wr_idx < CW'(DEPTH)) begin
            entries_nxt[wr_idx[AW-1:0]] = push_uop;
            wr_idx = wr_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            count <= wr_idx;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= entries_nxt[i];
            end
        end
    end

    assign head  = entries[0];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/wb_result_arbiter.sv
// Single writeback bus: fast FU results always win, slow FU results queue in a
// flushable buffer (or bypass it when idle), with a starvation hint upstream.
module wb_result_arbiter
    import wb_result_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = FIFO_DEPTH_WB,
    parameter int STARVE_LIMIT = STARVE_LIMIT_WB
) (
    input  logic      clk,
    input  logic      rst,
    input  BranchProv IN_branch,
    input  logic      IN_fastValid,
    input  RES_UOp    IN_fastUOp,
    input  logic      IN_slowValid,
    input  RES_UOp    IN_slowUOp,
    output logic      OUT_slowReady,
    output logic      OUT_resultValid,
    output RES_UOp    OUT_resultUOp,
    output logic      OUT_holdFast
);

    RES_UOp     head;
    logic       full;
    logic       empty;
    logic       flush;
    logic       fast_keep;
    logic       head_keep;
    logic       pop;
    logic       push;
    logic       slow_keep;
    logic       bypass;
    logic       fifo_push;
    logic [3:0] starve_cnt;

    assign flush     = IN_branch.taken;
    assign fast_keep = IN_fastValid && !(flush && sqn_younger(IN_fastUOp.sqN, IN_branch.sqN));
    assign head_keep = !empty && !(flush && sqn_younger(head.sqN, IN_branch.sqN));
    assign pop       = !fast_keep && head_keep;

    // Slow handshake: a transfer happens when IN_slowValid && OUT_slowReady.
    // A transfer killed by a flush is still a completed transfer.
    assign OUT_slowReady = !full || pop;
    assign push          = IN_slowValid && OUT_slowReady;
    assign slow_keep     = push && !(flush && sqn_younger(IN_slowUOp.sqN, IN_branch.sqN));
    assign bypass        = slow_keep && empty && !fast_keep;
    assign fifo_push     = slow_keep && !bypass;

    wb_flush_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_uop  (IN_slowUOp),
        .pop       (pop),
        .flush     (flush),
        .flush_sqn (IN_branch.sqN),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    // Emptying only happens through a pop or a flush, both of which clear the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (flush || pop) begin
            starve_cnt <= '0;
        end else if (fast_keep && !empty && starve_cnt != 4'hF) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            OUT_resultValid <= 1'b0;
            OUT_resultUOp   <= '0;
            OUT_holdFast    <= 1'b0;
        end else begin
            OUT_resultValid <= fast_keep || pop || bypass;
            OUT_resultUOp   <= fast_keep ? IN_fastUOp :
                               pop       ? head       :
                               bypass    ? IN_slowUOp : '0;
            OUT_holdFast    <= (starve_cnt >= 4'(STARVE_LIMIT)) && !empty;
        end
    end

endmodule

// File: tb/tb_wb_result_arbiter.sv
// Directed bench for wb_result_arbiter with hand-computed expected values.
module tb_wb_result_arbiter;
    import wb_result_arbiter_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    BranchProv branch;
    logic      fast_valid;
    RES_UOp    fast_uop;
    logic      slow_valid;
    RES_UOp    slow_uop;
    logic      slow_ready;
    logic      result_valid;
    RES_UOp    result_uop;
    logic      hold_fast;

    int n_checks = 0;
    int n_fail   = 0;

    wb_result_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .IN_branch       (branch),
        .IN_fastValid    (fast_valid),
        .IN_fastUOp      (fast_uop),
        .IN_slowValid    (slow_valid),
        .IN_slowUOp      (slow_uop),
        .OUT_slowReady   (slow_ready),
        .OUT_resultValid (result_valid),
        .OUT_resultUOp   (result_uop),
        .OUT_holdFast    (hold_fast)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic RES_UOp mk_uop(input logic [6:0] tag, input SqN sqn);
        RES_UOp u;
        u        = '0;
        u.tagDst = tag;
        u.sqN    = sqn;
        u.nmDst  = tag[4:0];
        u.result = {25'h0, tag};
        return u;
    endfunction

    task automatic idle_inputs();
        branch     = '0;
        fast_valid = 1'b0;
        fast_uop   = '0;
        slow_valid = 1'b0;
        slow_uop   = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bus(input string tag, input logic exp_valid, input logic [6:0] exp_tag);
        check_eq({tag, "_valid"}, 32'(result_valid), 32'(exp_valid));
        if (exp_valid) begin
            check_eq({tag, "_tag"}, 32'(result_uop.tagDst), 32'(exp_tag));
            check_eq({tag, "_res"}, result_uop.result, {25'h0, exp_tag});
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        check_eq("rst_valid", 32'(result_valid), 32'd0);
        check_eq("rst_hold", 32'(hold_fast), 32'd0);
        check_eq("rst_uop", result_uop.result, 32'd0);
        check_eq("rst_ready", 32'(slow_ready), 32'd1);
        rst = 1'b0;

        // Fast only
        for (int k = 0; k < 3; k++) begin
            fast_valid = 1'b1;
            fast_uop   = mk_uop(7'(5 + k), 7'(1 + k));
            #1;
            check_eq("fast_ready", 32'(slow_ready), 32'd1);
            tick();
            check_bus("fast_out", 1'b1, 7'(5 + k));
        end
        idle_inputs();
        tick();
        check_bus("fast_idle", 1'b0, 7'h0);

        // Slow bypass: straight to the bus, nothing stored
        slow_valid = 1'b1;
        slow_uop   = mk_uop(7'h12, 7'd4);
        #1;
        check_eq("byp_ready", 32'(slow_ready), 32'd1);
        tick();
        check_bus("byp_out", 1'b1, 7'h12);
        idle_inputs();
        tick();
        check_bus("byp_nostore", 1'b0, 7'h0);

        // Fill and back-pressure
        for (int k = 0; k < 5; k++) begin
            fast_valid = 1'b1;
            fast_uop   = mk_uop(7'(8'h20 + k), 7'(8'h20 + k));
            slow_valid = 1'b1;
            slow_uop   = mk_uop(7'(8'h30 + k), 7'(8'h40 + k));
            #1;
            check_eq("fill_ready", 32'(slow_ready), (k < 4) ? 32'd1 : 32'd0);
            tick();
            check_bus("fill_out", 1'b1, 7'(8'h20 + k));
            check_eq("fill_hold", 32'(hold_fast), (k == 4) ? 32'd1 : 32'd0);
        end
        idle_inputs();
        for (int d = 0; d < 4; d++) begin
            tick();
            check_bus("drain_out", 1'b1, 7'(8'h30 + d));
            if (d == 0) check_eq("drain_hold0", 32'(hold_fast), 32'd1);
            if (d == 1) check_eq("drain_hold1", 32'(hold_fast), 32'd0);
        end
        tick();
        check_bus("drain_done", 1'b0, 7'h0);

        // Flush: buffered sqN 10,12,14,16; branch sqN 12
        for (int k = 0; k < 4; k++) begin
            fast_valid = 1'b1;
            fast_uop   = mk_uop(7'(8'h60 + k), 7'(5 + k));
            slow_valid = 1'b1;
            slow_uop   = mk_uop(7'(8'h40 + k), 7'(10 + 2 * k));
            tick();
            check_bus("fl_fill", 1'b1, 7'(8'h60 + k));
        end
        branch.taken = 1'b1;
        branch.sqN   = 7'd12;
        fast_valid   = 1'b1;
        fast_uop     = mk_uop(7'h4F, 7'd14);
        slow_valid   = 1'b1;
        slow_uop     = mk_uop(7'h44, 7'd13);
        #1;
        check_eq("fl_ready", 32'(slow_ready), 32'd1);
        tick();
        check_bus("fl_head10", 1'b1, 7'h40);
        idle_inputs();
        tick();
        check_bus("fl_head12", 1'b1, 7'h41);
        tick();
        check_bus("fl_gone1", 1'b0, 7'h0);
        tick();
        check_bus("fl_gone2", 1'b0, 7'h0);

        // Wrap-around flush, equal sqN kept
        fast_valid = 1'b1;
        fast_uop   = mk_uop(7'h61, 7'h70);
        slow_valid = 1'b1;
        slow_uop   = mk_uop(7'h50, 7'h7C);
        tick();
        fast_uop   = mk_uop(7'h62, 7'h71);
        slow_uop   = mk_uop(7'h51, 7'h01);
        tick();
        slow_valid   = 1'b0;
        branch.taken = 1'b1;
        branch.sqN   = 7'h7E;
        fast_uop     = mk_uop(7'h52, 7'h7E);
        tick();
        check_bus("wr_equal", 1'b1, 7'h52);
        idle_inputs();
        tick();
        check_bus("wr_kept", 1'b1, 7'h50);
        tick();
        check_bus("wr_flushed", 1'b0, 7'h0);

        // Reset mid-operation
        for (int k = 0; k < 5; k++) begin
            fast_valid = 1'b1;
            fast_uop   = mk_uop(7'(8'h08 + k), 7'(8'h08 + k));
            slow_valid = (k < 3);
            slow_uop   = mk_uop(7'(8'h70 + k), 7'(8'h10 + k));
            tick();
            if (k == 3) check_eq("rs_hold3", 32'(hold_fast), 32'd0);
            if (k == 4) check_eq("rs_hold4", 32'(hold_fast), 32'd1);
        end
        idle_inputs();
        rst = 1'b1;
        tick();
        check_eq("rs_valid", 32'(result_valid), 32'd0);
        check_eq("rs_hold", 32'(hold_fast), 32'd0);
        check_eq("rs_ready", 32'(slow_ready), 32'd1);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_bus("rs_nodrain", 1'b0, 7'h0);
            check_eq("rs_nohold", 32'(hold_fast), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
